// File: rtl/matrix_inv_arbiter.sv
// Round-robin arbiter sharing one 2x2 Q2.14 matrix-inversion engine between N_REQ requesters.
// Grants, issues the latched matrix, waits under a watchdog and holds the tagged response.
module matrix_inv_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned ID_W        = 2,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [N_REQ-1:0]      req_valid_i,
  output logic [N_REQ-1:0]      req_ready_o,
  input  logic [16*N_REQ-1:0]   req_a_i,
  input  logic [16*N_REQ-1:0]   req_b_i,
  input  logic [16*N_REQ-1:0]   req_c_i,
  input  logic [16*N_REQ-1:0]   req_d_i,
  output logic                  eng_start_o,
  output logic [15:0]           eng_a_o,
  output logic [15:0]           eng_b_o,
  output logic [15:0]           eng_c_o,
  output logic [15:0]           eng_d_o,
  input  logic                  eng_done_i,
  input  logic [15:0]           eng_a_inv_i,
  input  logic [15:0]           eng_b_inv_i,
  input  logic [15:0]           eng_c_inv_i,
  input  logic [15:0]           eng_d_inv_i,
  input  logic                  eng_error_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [ID_W-1:0]       resp_id_o,
  output logic [15:0]           resp_a_o,
  output logic [15:0]           resp_b_o,
  output logic [15:0]           resp_c_o,
  output logic [15:0]           resp_d_o,
  output logic                  resp_error_o,
  output logic                  resp_timeout_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0][15:0]  op_q, op_d;
  logic [3:0][15:0]  res_q, res_d;
  logic              err_q, err_d;
  logic              tmo_q, tmo_d;

  logic              lo_found, hi_found;
  logic [ID_W-1:0]   lo_id, hi_id, win_id;
  logic [3:0][15:0]  sel_op;

  // Lowest set bit at/above the pointer wins; otherwise wrap to the lowest set bit overall.
  always_comb begin
    lo_found = 1'b0;
    hi_found = 1'b0;
    lo_id    = '0;
    hi_id    = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (req_valid_i[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_id    = ID_W'(i);
      end
      if (req_valid_i[i] && (ID_W'(i) >= rr_q) && !hi_found) begin
        hi_found = 1'b1;
        hi_id    = ID_W'(i);
      end
    end
    win_id = hi_found ? hi_id : lo_id;
  end

  always_comb begin
    sel_op = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (id_q == ID_W'(i)) begin
        sel_op = {req_d_i[16*i +: 16], req_c_i[16*i +: 16],
                  req_b_i[16*i +: 16], req_a_i[16*i +: 16]};
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    id_d    = id_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    res_d   = res_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      StIdle: begin
        // Two IDLE cycles: decide and register the grant, then latch operands on the strobe.
        if (gnt_q != '0) begin
          op_d    = sel_op;
          state_d = StIssue;
        end else if (lo_found) begin
          gnt_d = N_REQ'(1) << win_id;
          id_d  = win_id;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (eng_done_i) begin
          res_d   = {eng_d_inv_i, eng_c_inv_i, eng_b_inv_i, eng_a_inv_i};
          err_d   = eng_error_i;
          tmo_d   = 1'b0;
          state_d = StResp;
        end else if (cnt_d == CNT_W'(TIMEOUT_CYC - 1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        if (resp_ready_i) begin
          rr_d    = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      id_q    <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      res_q   <= res_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  assign req_ready_o    = gnt_q;
  assign eng_start_o    = (state_q == StIssue);
  assign eng_a_o        = op_q[0];
  assign eng_b_o        = op_q[1];
  assign eng_c_o        = op_q[2];
  assign eng_d_o        = op_q[3];
  assign resp_valid_o   = (state_q == StResp);
  assign resp_id_o      = id_q;
  assign resp_a_o       = res_q[0];
  assign resp_b_o       = res_q[1];
  assign resp_c_o       = res_q[2];
  assign resp_d_o       = res_q[3];
  assign resp_error_o   = err_q;
  assign resp_timeout_o = tmo_q;

  grant_onehot_a: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_q));
  grant_idle_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                 (gnt_q != '0) |-> (state_q == StIdle));

endmodule

// File: tb/tb_matrix_inv_arbiter.sv
// Bench for matrix_inv_arbiter: vector table plus hand sequences for watchdog,
// backpressure and mid-transaction reset; responses checked against a scoreboard queue.
module tb_matrix_inv_arbiter;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned ID_W  = 2;
  localparam int unsigned TMO   = 64;

  typedef struct packed {
    logic [1:0]       id;
    logic [3:0][15:0] res;
    logic             err;
    logic             tmo;
  } resp_t;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] after;
    int         lat;
    logic [1:0] id;
  } vec_t;

  logic clk, rst_n;
  logic [3:0] req_valid, req_ready;
  logic [63:0] req_a, req_b, req_c, req_d;
  logic eng_start, eng_done, stray_done, eng_err;
  logic [15:0] eng_a, eng_b, eng_c, eng_d;
  logic [15:0] inv_a, inv_b, inv_c, inv_d;
  logic resp_valid, resp_ready, resp_error, resp_timeout;
  logic [1:0] resp_id;
  logic [15:0] resp_a, resp_b, resp_c, resp_d;

  logic [3:0][15:0] ops [4];
  resp_t exp_q[$];
  resp_t act_resp, mon_exp, hold_exp;
  vec_t vecs [11];
  int n_tests, n_fail, cyc, eng_lat, t0, n;
  bit eng_hang;

  matrix_inv_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .TIMEOUT_CYC(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b), .req_c_i(req_c), .req_d_i(req_d),
    .eng_start_o(eng_start),
    .eng_a_o(eng_a), .eng_b_o(eng_b), .eng_c_o(eng_c), .eng_d_o(eng_d),
    .eng_done_i(eng_done | stray_done),
    .eng_a_inv_i(inv_a), .eng_b_inv_i(inv_b), .eng_c_inv_i(inv_c), .eng_d_inv_i(inv_d),
    .eng_error_i(eng_err),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_id_o(resp_id),
    .resp_a_o(resp_a), .resp_b_o(resp_b), .resp_c_o(resp_c), .resp_d_o(resp_d),
    .resp_error_o(resp_error), .resp_timeout_o(resp_timeout)
  );

  assign req_a = {ops[3][0], ops[2][0], ops[1][0], ops[0][0]};
  assign req_b = {ops[3][1], ops[2][1], ops[1][1], ops[0][1]};
  assign req_c = {ops[3][2], ops[2][2], ops[1][2], ops[0][2]};
  assign req_d = {ops[3][3], ops[2][3], ops[1][3], ops[0][3]};
  assign act_resp = {resp_id, resp_d, resp_c, resp_b, resp_a, resp_error, resp_timeout};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference 2x2 Q2.14 inverse; singular when the Q2.14 determinant is zero.
  function automatic void inv_model(input logic [3:0][15:0] m, output logic [3:0][15:0] r,
                                    output logic err);
    longint sa, sb, sc, sd, det;
    sa  = longint'($signed(m[0]));
    sb  = longint'($signed(m[1]));
    sc  = longint'($signed(m[2]));
    sd  = longint'($signed(m[3]));
    det = (sa * sd - sb * sc) >>> 14;
    if (det == 0) begin
      err = 1'b1;
      r   = '0;
    end else begin
      err  = 1'b0;
      r[0] = 16'((sd <<< 14) / det);
      r[1] = 16'(((-sb) <<< 14) / det);
      r[2] = 16'(((-sc) <<< 14) / det);
      r[3] = 16'((sa <<< 14) / det);
    end
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Engine stub: sees eng_start, answers eng_lat cycles later unless hung.
  initial begin
    logic [3:0][15:0] r;
    logic e;
    eng_done = 1'b0;
    eng_err  = 1'b0;
    {inv_d, inv_c, inv_b, inv_a} = '0;
    forever begin
      @(negedge clk);
      if (eng_start === 1'b1 && !eng_hang) begin
        inv_model({eng_d, eng_c, eng_b, eng_a}, r, e);
        repeat (eng_lat) @(posedge clk);
        #1;
        eng_done = 1'b1;
        eng_err  = e;
        {inv_d, inv_c, inv_b, inv_a} = r;
        @(posedge clk);
        #1 eng_done = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected response: got %0h, expected none", act_resp);
      end else begin
        mon_exp = exp_q.pop_front();
        check("response", act_resp, mon_exp);
      end
    end
  end

  task automatic grant_step(input logic [3:0] v, input logic [3:0] after, input logic [1:0] id,
                            input bit push);
    resp_t e;
    int k;
    @(posedge clk);
    #1 req_valid = v;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (req_ready == 4'b0 && k < 1000);
    check("grant", req_ready, 4'b1 << id);
    if (push) begin
      inv_model(ops[id], e.res, e.err);
      e.id  = id;
      e.tmo = 1'b0;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1 req_valid = after;
    @(negedge clk);
    check("start after grant", {eng_start, req_ready}, {1'b1, 4'b0});
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    cyc = 0;
    rst_n = 1'b0;
    req_valid = 4'b1111;
    resp_ready = 1'b1;
    stray_done = 1'b0;
    eng_hang = 1'b0;
    eng_lat = 4;
    ops[0] = {16'h4000, 16'h0000, 16'h0000, 16'h4000};
    ops[1] = {16'h4000, 16'h0000, 16'h1000, 16'h4000};
    ops[2] = {16'h2000, 16'h2000, 16'h2000, 16'h2000};
    ops[3] = {16'h0000, 16'h4000, 16'h4000, 16'h0000};
    vecs[0]  = '{4'b0001, 4'b0000, 40, 2'd0};
    vecs[1]  = '{4'b1111, 4'b1111, 5, 2'd1};
    vecs[2]  = '{4'b1111, 4'b1111, 5, 2'd2};
    vecs[3]  = '{4'b1111, 4'b1111, 5, 2'd3};
    vecs[4]  = '{4'b1111, 4'b1111, 5, 2'd0};
    vecs[5]  = '{4'b1111, 4'b0000, 5, 2'd1};
    vecs[6]  = '{4'b0100, 4'b0000, 8, 2'd2};
    vecs[7]  = '{4'b1010, 4'b0000, 3, 2'd3};
    vecs[8]  = '{4'b1010, 4'b0000, 3, 2'd1};
    vecs[9]  = '{4'b1001, 4'b0000, 1, 2'd3};
    vecs[10] = '{4'b0001, 4'b0000, 2, 2'd0};

    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", {req_ready, eng_start, eng_a, eng_b, eng_c, eng_d, resp_valid,
                            act_resp}, '0);
    req_valid = 4'b0000;
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      eng_lat = vecs[i].lat;
      grant_step(vecs[i].valid, vecs[i].after, vecs[i].id, 1'b1);
      wait_drain();
    end

    // Watchdog with a hung engine, then a stray done while the response is held.
    eng_hang = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    grant_step(4'b0010, 4'b0000, 2'd1, 1'b0);
    exp_q.push_back('{id: 2'd1, res: '0, err: 1'b1, tmo: 1'b1});
    t0 = cyc;
    n = 0;
    while (!resp_valid && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("watchdog latency", cyc - t0, TMO);
    check("timeout resp", {resp_valid, act_resp}, {1'b1, exp_q[0]});
    @(posedge clk);
    #1 stray_done = 1'b1;
    @(posedge clk);
    #1 stray_done = 1'b0;
    @(negedge clk);
    check("stray done ignored", {resp_valid, act_resp}, {1'b1, exp_q[0]});
    @(posedge clk);
    #1 resp_ready = 1'b1;
    eng_hang = 1'b0;
    wait_drain();

    // Backpressure with every requester valid.
    eng_lat = 6;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    grant_step(4'b1111, 4'b1111, 2'd2, 1'b1);
    hold_exp = exp_q[0];
    n = 0;
    while (!resp_valid && n < 1000) begin
      @(negedge clk);
      n++;
    end
    repeat (20) begin
      @(negedge clk);
      check("backpressure hold", {resp_valid, act_resp, req_ready, eng_start},
            {1'b1, hold_exp, 4'b0, 1'b0});
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    grant_step(4'b1111, 4'b0000, 2'd3, 1'b1);
    wait_drain();
    grant_step(4'b0010, 4'b0000, 2'd1, 1'b1);
    wait_drain();

    // Reset mid-WAIT: pointer must return to requester 0.
    eng_hang = 1'b1;
    grant_step(4'b0101, 4'b0000, 2'd2, 1'b0);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async reset outputs", {req_ready, eng_start, eng_a, eng_b, eng_c, eng_d, resp_valid,
                                  act_resp}, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    eng_hang = 1'b0;
    eng_lat = 5;
    grant_step(4'b1001, 4'b0000, 2'd0, 1'b1);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
